// File: rtl/puf_eval_controller.sv
// puf_eval_controller: LFSR-driven arbiter-PUF launcher that majority-votes repeated
// responses, flags non-unanimous bits and hands results out over valid/ready.
module puf_eval_controller #(
  parameter int C_LENGTH = 8,
  parameter int R_WIDTH = 7,
  parameter int VOTES = 5,
  parameter int SETTLE = 4,
  parameter logic [C_LENGTH-1:0] SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                seed_load,
  input  logic [C_LENGTH-1:0] seed,
  output logic [C_LENGTH-1:0] challenge,
  output logic                launch_pulse,
  input  logic [R_WIDTH-1:0]  puf_resp,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [R_WIDTH-1:0]  resp_data,
  output logic [R_WIDTH-1:0]  resp_unstable,
  output logic [C_LENGTH-1:0] resp_chal,
  output logic                busy
);
  localparam int CW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE + 1);
  // An all-zero LFSR state would lock up, so zero seeds are replaced by 1.
  localparam logic [C_LENGTH-1:0] SEED_OK = (SEED == '0) ? C_LENGTH'(1) : SEED;
  typedef enum logic [2:0] {IDLE, APPLY, FIRE, SAMPLE, RECOVER, DONE} state_t;
  state_t st, nxt;
  logic [R_WIDTH-1:0] sync1, sync2, data_d, unst_d;
  logic [R_WIDTH-1:0][CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [SW-1:0] settle_cnt;
  logic [C_LENGTH-1:0] lfsr, lfsr_nxt;
  logic pulse_d, valid_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = (start && !seed_load) ? APPLY : IDLE;
      APPLY:   nxt = FIRE;
      FIRE:    nxt = (settle_cnt == SW'(SETTLE - 1)) ? SAMPLE : FIRE;
      SAMPLE:  nxt = RECOVER;
      RECOVER: nxt = (idx < CW'(VOTES)) ? FIRE : DONE;
      DONE:    nxt = resp_ready ? (start ? APPLY : IDLE) : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    pulse_d = nxt == FIRE;
    valid_d = nxt == DONE;
    busy = st != IDLE;
    lfsr_nxt = {lfsr[C_LENGTH-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    data_d = '0;
    unst_d = '0;
    for (int i = 0; i < R_WIDTH; i++) begin
      data_d[i] = cnt[i] > CW'(VOTES / 2);
      unst_d[i] = (cnt[i] != '0) && (cnt[i] != CW'(VOTES));
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      challenge <= '0;
      launch_pulse <= 1'b0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_unstable <= '0;
      resp_chal <= '0;
      lfsr <= SEED_OK;
      cnt <= '0;
      idx <= '0;
      settle_cnt <= '0;
    end else begin
      sync1 <= puf_resp;
      sync2 <= sync1;
      launch_pulse <= pulse_d;
      resp_valid <= valid_d;
      settle_cnt <= (st == FIRE) ? settle_cnt + SW'(1) : '0;
      if (st == IDLE && seed_load) lfsr <= (seed == '0) ? C_LENGTH'(1) : seed;
      else if (st == DONE && resp_ready) lfsr <= lfsr_nxt;
      if (st == APPLY) begin
        challenge <= lfsr;
        cnt <= '0;
        idx <= '0;
      end
      if (st == SAMPLE) begin
        for (int i = 0; i < R_WIDTH; i++) cnt[i] <= cnt[i] + CW'(sync2[i]);
        idx <= idx + CW'(1);
      end
      // Result registers load once on entry to DONE and hold through any stall.
      if (st == RECOVER && valid_d) begin
        resp_data <= data_d;
        resp_unstable <= unst_d;
        resp_chal <= challenge;
      end
    end
endmodule

// File: tb/tb_puf_eval_controller.sv
// tb_puf_eval_controller: directed vectors plus hand-built sequences for the
// PUF evaluation controller; the bench plays the PUF by driving puf_resp per launch.
module tb_puf_eval_controller;
  logic clk = 1'b0;
  logic rst_n, start, seed_load, resp_ready, launch_pulse, resp_valid, busy;
  logic [7:0] seed, challenge, resp_chal;
  logic [6:0] puf_resp, resp_data, resp_unstable;
  int checks = 0;
  int fails = 0;
  int n;
  puf_eval_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed(seed),
    .challenge(challenge), .launch_pulse(launch_pulse), .puf_resp(puf_resp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_unstable(resp_unstable), .resp_chal(resp_chal), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Launch hygiene: challenge steady while pulse high, >=2 low cycles between launches.
  logic pp = 1'b0;
  logic [7:0] pc = '0;
  int low_run = 0;
  bit seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
      low_run = 0;
    end else begin
      if (launch_pulse && pp) chk("chal_hold", challenge, pc);
      if (launch_pulse && !pp) begin
        if (seen) chk("rearm_gap", 32'(low_run >= 2), 1);
        seen = 1;
        low_run = 0;
      end
      if (!launch_pulse) low_run++;
    end
    pp = launch_pulse;
    pc = challenge;
  end
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    resp_ready = 1'b1;
    puf_resp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_pulse(input logic lvl);
    int t = 0;
    while (launch_pulse !== lvl && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (launch_pulse !== lvl) chk("pulse_timeout", 32'(launch_pulse), 32'(lvl));
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 200);
    if (!resp_valid) chk("valid_timeout", 32'(resp_valid), 1);
  endtask
  task automatic feed(input logic [4:0][6:0] p);
    for (int k = 0; k < 5; k++) begin
      wait_pulse(1'b1);
      puf_resp = p[4-k];
      wait_pulse(1'b0);
    end
  endtask
  typedef struct {
    logic [7:0] seed;
    logic [4:0][6:0] pat;
    logic [6:0] data;
    logic [6:0] unst;
    logic [7:0] chal;
  } vec_t;
  vec_t tv[7];
  logic [7:0] seq_chal[5];
  int viol;
  initial begin
    tv[0] = '{8'h01, {5{7'h55}}, 7'h55, 7'h00, 8'h01};
    tv[1] = '{8'h00, {7'h01, 7'h01, 7'h01, 7'h00, 7'h00}, 7'h01, 7'h01, 8'h01};
    tv[2] = '{8'h80, {7'h01, 7'h01, 7'h00, 7'h00, 7'h00}, 7'h00, 7'h01, 8'h80};
    tv[3] = '{8'hFF, {7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F}, 7'h7F, 7'h7F, 8'hFF};
    tv[4] = '{8'h3C, {5{7'h00}}, 7'h00, 7'h00, 8'h3C};
    tv[5] = '{8'h5A, {7'h03, 7'h06, 7'h0C, 7'h18, 7'h30}, 7'h00, 7'h3F, 8'h5A};
    tv[6] = '{8'hC3, {7'h70, 7'h70, 7'h70, 7'h70, 7'h10}, 7'h70, 7'h60, 8'hC3};
    seq_chal = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    chk("rst_state", {challenge, launch_pulse, resp_valid, busy, resp_data, resp_unstable, 1'b0},
        32'h0);
    chk("rst_chal", resp_chal, 8'h00);
    for (int v = 0; v < 7; v++) begin
      do_reset();
      seed = tv[v].seed;
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(tv[v].pat);
      wait_valid(n);
      chk($sformatf("vec%0d_data", v), resp_data, tv[v].data);
      chk($sformatf("vec%0d_unst", v), resp_unstable, tv[v].unst);
      chk($sformatf("vec%0d_chal", v), resp_chal, tv[v].chal);
      @(negedge clk);
      chk($sformatf("vec%0d_idle", v), {busy, resp_valid}, 2'b00);
    end
    // Continuous run from seed 01: latency, throughput and LFSR sequence.
    do_reset();
    puf_resp = 7'h55;
    seed = 8'h01;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b1;
    wait_valid(n);
    chk("latency", n, 32);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("seq%0d_chal", j), resp_chal, seq_chal[j]);
      chk($sformatf("seq%0d_data", j), {resp_data, resp_unstable}, {7'h55, 7'h00});
      if (j == 4) start = 1'b0;
      else begin
        wait_valid(n);
        chk($sformatf("seq%0d_period", j), n, 32);
      end
    end
    repeat (2) @(negedge clk);
    chk("seq_idle", busy, 0);
    // Back-pressure: result held, no new launch until handshake.
    do_reset();
    puf_resp = 7'h55;
    resp_ready = 1'b0;
    start = 1'b1;
    wait_valid(n);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", c), {resp_valid, launch_pulse, resp_chal, resp_data, challenge},
          {1'b1, 1'b0, 8'hA5, 7'h55, 8'hA5});
    end
    resp_ready = 1'b1;
    wait_pulse(1'b1);
    chk("post_stall_chal", challenge, 8'h4A);
    wait_valid(n);
    chk("post_stall_resp_chal", resp_chal, 8'h4A);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_stall_idle", busy, 0);
    // Asynchronous reset while the race is being launched.
    do_reset();
    start = 1'b1;
    wait_pulse(1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {launch_pulse, resp_valid, busy, challenge}, 11'h000);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst", {busy, challenge}, 9'h000);
    puf_resp = 7'h2A;
    start = 1'b1;
    wait_pulse(1'b1);
    chk("after_rst_chal", challenge, 8'hA5);
    wait_valid(n);
    chk("after_rst_resp", {resp_chal, resp_data}, {8'hA5, 7'h2A});
    start = 1'b0;
    repeat (2) @(negedge clk);
    // start dropped during SAMPLE of the second vote.
    do_reset();
    puf_resp = 7'h55;
    start = 1'b1;
    for (int v = 0; v < 2; v++) begin
      wait_pulse(1'b1);
      wait_pulse(1'b0);
    end
    start = 1'b0;
    wait_valid(n);
    chk("drop_resp", {resp_chal, resp_data}, {8'hA5, 7'h55});
    @(negedge clk);
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy || resp_valid || launch_pulse) viol++;
      @(negedge clk);
    end
    chk("drop_idle", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
